uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameters SHALL be:
- DATA_BITS, 8: data bits per frame, legal 5..9.
- STOP_BITS, 1: stop bits, legal 1 or 2.
- PARITY_MODE, 0: 2-bit parity select; 0 none, 1 even, 2 odd, 3 mark (always 1).
- FIFO_DEPTH, 16: entries; power of two, >= 2.
- DIV_W, 16: width of the runtime baud divisor.
REQ-002 Ports SHALL be, in this order:
- clk, in, 1: the single clock.
- rst, in, 1: synchronous, active-high reset.
- dat, in, DATA_BITS: write data.
- val, in, 1: write valid.
- rdy, out, 1: FIFO not full.
- div, in, DIV_W: clk cycles per bit.
- tx, out, 1: serial line, idle high.
- busy, out, 1: frame in progress or FIFO non-empty.
- level, out, $clog2(FIFO_DEPTH)+1: FIFO occupancy.

Function
REQ-003 A write SHALL be accepted on a rising edge where val && rdy; val while !rdy SHALL be ignored, with no data or state change.
REQ-004 rdy SHALL be combinational: level != FIFO_DEPTH.
REQ-005 The FIFO SHALL preserve write order and wrap its pointers modulo FIFO_DEPTH.
REQ-006 When FIFO_DEPTH-1 entries are held, a simultaneous write and pop SHALL leave level unchanged.
REQ-007 The FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-008 In IDLE with the FIFO non-empty, the FSM SHALL pop one word, latch it, latch the effective divisor, and enter START on the same edge.
REQ-009 The effective divisor SHALL be max(div, 2); a change to div mid-frame SHALL NOT affect the current frame.
REQ-010 tx SHALL be registered.
REQ-011 tx SHALL go low on the edge that enters START, so a word written into an empty, idle block drives tx low 2 edges after acceptance.
REQ-012 START, each DATA bit and PARITY SHALL each last exactly D clk cycles, where D is the latched divisor.
REQ-013 STOP SHALL last STOP_BITS*D cycles.
REQ-014 Data SHALL be sent LSB first, bit 0 first.
REQ-015 A bit counter SHALL count DATA_BITS bits, then go to PARITY if PARITY_MODE != 0, else to STOP.
REQ-016 The parity bit SHALL be: even, XOR of the data bits; odd, its inverse; mark, 1.
REQ-017 At the end of STOP with the FIFO non-empty, the FSM SHALL pop and enter START directly, leaving no idle cycles between frames; otherwise it SHALL enter IDLE with tx = 1.
REQ-018 busy SHALL be (state != IDLE) || (level != 0).
REQ-019 The baud counter SHALL be DIV_W bits wide and SHALL reload to 0 at every bit boundary.
REQ-020 Illegal FSM encodings SHALL return to IDLE with tx = 1 on the next edge.

Reset
REQ-021 While rst is high: state SHALL be IDLE, tx = 1, level = 0, rdy = 1, busy = 0, and pointers and counters SHALL be 0.
REQ-022 rst asserted mid-frame SHALL abort the frame, drive tx high on the next edge, and discard all FIFO contents.
REQ-023 Writes presented while rst is high SHALL be dropped.

Verification
REQ-024 Defaults, div=4, write 0xA5 into an idle block -> tx low 2 edges later for 4 cycles, then 1,0,1,0,0,1,0,1 each for 4 cycles, then high for 4 cycles; busy clears when the frame ends.
REQ-025 PARITY_MODE=1, DATA_BITS=7, STOP_BITS=2, div=3, write 0x03 -> START, 1,1,0,0,0,0,0, parity 0, two stop bits; 33 cycles total.
REQ-026 FIFO_DEPTH=4, div=2, write 6 words back-to-back -> rdy low after the 5th accept (1 in flight plus 4 queued); the 6th is stalled and later accepted; all 6 frames are sent back-to-back in order with no idle gap.
REQ-027 div=0 and div=1 -> each bit lasts 2 cycles; changing div from 4 to 8 mid-frame -> the current frame stays at 4, the next frame uses 8.
REQ-028 Assert rst during the DATA bit 3 of a frame with 2 words queued -> tx=1, level=0 and busy=0 the edge after; with no new writes, no further start bits appear.
REQ-029 PARITY_MODE=2 with 0x00 -> parity bit 1; PARITY_MODE=3 with any data -> parity bit 1.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a write FIFO. Frames are start, DATA_BITS LSB first,
// an optional parity bit and STOP_BITS stop bits, each bit lasting max(div,2) clocks.
module uart_tx_fifo #(
  parameter int DATA_BITS   = 8,
  parameter int STOP_BITS   = 1,
  parameter int PARITY_MODE = 0,
  parameter int FIFO_DEPTH  = 16,
  parameter int DIV_W       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          dat,
  input  logic                          val,
  output logic                          rdy,
  input  logic [DIV_W-1:0]              div,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = 4;
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Handshake: a word is taken on every rising edge where val && rdy; rdy
  // depends only on occupancy, so a pop on the same edge cannot make room.
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wptr_q, rptr_q;
  logic [AW:0]          count_q;
  logic                 push, pop;

  assign rdy   = (count_q != FULL);
  assign push  = val && rdy;
  assign level = count_q;

  always_ff @(posedge clk) begin
    if (push && !rst) mem[wptr_q] <= dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    case (PARITY_MODE)
      1:       return ^d;
      2:       return ~^d;
      default: return 1'b1;
    endcase
  endfunction

  state_t               state_q, state_d;
  logic [DIV_W-1:0]     cnt_q, cnt_d, div_q, div_d, eff_div;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 last, load;

  assign eff_div = (div < DIV_W'(2)) ? DIV_W'(2) : div;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    div_d   = div_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    load    = 1'b0;
    last    = (cnt_q == div_q - 1'b1);
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        load  = (count_q != '0);
      end
      START: if (last) begin
        cnt_d   = '0;
        bit_d   = '0;
        state_d = DATA;
        tx_d    = shift_q[0];
        shift_d = shift_q >> 1;
      end
      DATA: if (last) begin
        cnt_d = '0;
        if (bit_q == BW'(DATA_BITS-1)) begin
          if (PARITY_MODE != 0) begin
            state_d = PARITY;
            tx_d    = par_q;
          end else begin
            state_d = STOP;
            tx_d    = 1'b1;
            stop_d  = 1'b0;
          end
        end else begin
          bit_d   = bit_q + 1'b1;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      PARITY: if (last) begin
        cnt_d   = '0;
        state_d = STOP;
        tx_d    = 1'b1;
        stop_d  = 1'b0;
      end
      STOP: if (last) begin
        cnt_d = '0;
        if (stop_q == 1'(STOP_BITS-1)) begin
          state_d = IDLE;
          tx_d    = 1'b1;
          load    = (count_q != '0);
        end else begin
          stop_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        cnt_d   = '0;
      end
    endcase
    // Taking the next word overrides IDLE/STOP-exit so frames run back-to-back.
    if (load) begin
      pop     = 1'b1;
      shift_d = mem[rptr_q];
      par_d   = parity_of(mem[rptr_q]);
      div_d   = eff_div;
      state_d = START;
      tx_d    = 1'b0;
      cnt_d   = '0;
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: five differently configured instances checked every cycle
// against a queue-based line model, plus hand-computed frame expectations.
module tb_uart_tx_fifo;

  localparam int NI = 5;

  function automatic int db_of(input int i);
    case (i) 1: return 7; 3: return 5; 4: return 9; default: return 8; endcase
  endfunction
  function automatic int sb_of(input int i);
    case (i) 1: return 2; 4: return 2; default: return 1; endcase
  endfunction
  function automatic int pm_of(input int i);
    case (i) 1: return 1; 3: return 2; 4: return 3; default: return 0; endcase
  endfunction
  function automatic int dep_of(input int i);
    case (i) 2: return 4; 3: return 2; 4: return 8; default: return 16; endcase
  endfunction

  logic                  clk, rst;
  logic [NI-1:0]         val_a, tx_w, busy_w, rdy_w;
  logic [NI-1:0][8:0]    dat_a;
  logic [NI-1:0][15:0]   div_a;
  logic [NI-1:0][4:0]    lvl;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int DB  = db_of(g);
    localparam int DEP = dep_of(g);
    logic [$clog2(DEP):0] lv;
    uart_tx_fifo #(
      .DATA_BITS(DB), .STOP_BITS(sb_of(g)), .PARITY_MODE(pm_of(g)),
      .FIFO_DEPTH(DEP), .DIV_W(16)
    ) u_dut (
      .clk(clk), .rst(rst), .dat(dat_a[g][DB-1:0]), .val(val_a[g]), .rdy(rdy_w[g]),
      .div(div_a[g]), .tx(tx_w[g]), .busy(busy_w[g]), .level(lv)
    );
    assign lvl[g] = 5'(lv);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;
  bit started = 0;

  task automatic chk(input string nm, input int i, input logic [15:0] act, input logic [15:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s inst=%0d t=%0t actual=%0h expected=%0h", nm, i, $time, act, want);
    end
  endtask

  // Line model: per instance, a queue of words waiting and a queue of future
  // tx samples (one per clock). A word leaves the FIFO whenever the line queue runs dry.
  logic        wave_q [NI][$];
  logic [8:0]  fifo_q [NI][$];
  logic [NI-1:0] exp_tx, exp_busy;
  int          exp_lvl [NI];

  task automatic push_bits(input int i, input logic b, input int n);
    for (int k = 0; k < n; k++) wave_q[i].push_back(b);
  endtask

  task automatic model_step(input int i);
    int d, pre;
    logic [8:0] w, m;
    logic p, inf;
    if (rst) begin
      fifo_q[i].delete();
      wave_q[i].delete();
      exp_tx[i] = 1'b1; exp_busy[i] = 1'b0; exp_lvl[i] = 0;
    end else begin
      pre = fifo_q[i].size();
      inf = 1'b0;
      if (wave_q[i].size() == 0 && pre > 0) begin
        w = fifo_q[i].pop_front();
        d = (div_a[i] < 16'd2) ? 2 : int'(div_a[i]);
        push_bits(i, 1'b0, d);
        p = 1'b0;
        for (int b = 0; b < db_of(i); b++) begin
          push_bits(i, w[b], d);
          p = p ^ w[b];
        end
        case (pm_of(i))
          1: push_bits(i, p, d);
          2: push_bits(i, ~p, d);
          3: push_bits(i, 1'b1, d);
          default: ;
        endcase
        push_bits(i, 1'b1, sb_of(i) * d);
      end
      m = 9'((32'd1 << db_of(i)) - 32'd1);
      if (val_a[i] && pre < dep_of(i)) fifo_q[i].push_back(dat_a[i] & m);
      if (wave_q[i].size() > 0) begin
        exp_tx[i] = wave_q[i].pop_front();
        inf = 1'b1;
      end else begin
        exp_tx[i] = 1'b1;
      end
      exp_busy[i] = inf || (fifo_q[i].size() != 0);
      exp_lvl[i]  = fifo_q[i].size();
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      for (int i = 0; i < NI; i++) model_step(i);
      started = 1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        for (int i = 0; i < NI; i++) begin
          chk("tx", i, 16'(tx_w[i]), 16'(exp_tx[i]));
          chk("busy", i, 16'(busy_w[i]), 16'(exp_busy[i]));
          chk("level", i, 16'(lvl[i]), 16'(exp_lvl[i]));
          chk("rdy", i, 16'(rdy_w[i]), 16'(exp_lvl[i] != dep_of(i)));
        end
      end
    end
  end

  task automatic wait_idle(input int i, input int lim);
    int k;
    k = 0;
    @(negedge clk);
    while (busy_w[i] !== 1'b0 && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk("idle_wait", i, 16'(busy_w[i]), 16'd0);
  endtask

  // Writes one word into an idle instance and checks tx sample by sample
  // against a hand-computed frame (bit 0 = start bit), dd clocks per bit.
  task automatic lit_frame(input int i, input logic [8:0] d, input logic [15:0] dv,
                           input int dd, input logic [15:0] frame, input int nb);
    wait_idle(i, 3000);
    @(posedge clk); #1;
    dat_a[i] = d; div_a[i] = dv; val_a[i] = 1'b1;
    @(posedge clk); #1;
    val_a[i] = 1'b0;
    @(negedge clk);
    chk("lit_pre", i, 16'(tx_w[i]), 16'd1);
    for (int n = 1; n <= nb * dd; n++) begin
      @(negedge clk);
      chk("lit_bit", i, 16'(tx_w[i]), 16'(frame[(n-1)/dd]));
    end
    @(negedge clk);
    chk("lit_end_tx", i, 16'(tx_w[i]), 16'd1);
    chk("lit_end_busy", i, 16'(busy_w[i]), 16'd0);
  endtask

  task automatic rand_phase(input int cycles, input int wr_pct);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 599) == 0);
      for (int i = 0; i < NI; i++) begin
        val_a[i] = ($urandom_range(0, 99) < wr_pct);
        dat_a[i] = 9'($urandom);
        if ($urandom_range(0, 15) == 0) div_a[i] = 16'($urandom_range(0, 5));
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    val_a = '0;
  endtask

  initial begin
    int k, cnt0;
    rst = 1'b1;
    val_a = '0;
    dat_a = '0;
    for (int i = 0; i < NI; i++) div_a[i] = 16'd4;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", 0, 16'(tx_w[0]), 16'd1);
    chk("rst_level", 0, 16'(lvl[0]), 16'd0);
    chk("rst_rdy", 0, 16'(rdy_w[0]), 16'd1);
    chk("rst_busy", 0, 16'(busy_w[0]), 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    lit_frame(0, 9'h0A5, 16'd4, 4, 16'h034A, 10);
    lit_frame(1, 9'h003, 16'd3, 3, 16'h0606, 11);
    lit_frame(3, 9'h000, 16'd2, 2, 16'h00C0, 8);
    lit_frame(4, 9'h0F0, 16'd5, 5, 16'h1DE0, 13);
    lit_frame(0, 9'h03C, 16'd0, 2, 16'h0278, 10);
    lit_frame(0, 9'h03C, 16'd1, 2, 16'h0278, 10);

    // Divisor change mid-frame: first frame keeps 4, second uses 8.
    wait_idle(0, 1000);
    @(posedge clk); #1;
    div_a[0] = 16'd4; dat_a[0] = 9'h05A; val_a[0] = 1'b1;
    @(posedge clk); #1;
    dat_a[0] = 9'h0C3;
    @(posedge clk); #1;
    val_a[0] = 1'b0;
    repeat (8) @(posedge clk);
    #1 div_a[0] = 16'd8;
    wait_idle(0, 1000);

    // Depth-4 FIFO filled back-to-back: full after the 5th accept.
    wait_idle(2, 1000);
    @(posedge clk); #1;
    div_a[2] = 16'd2;
    for (int w = 0; w < 6; w++) begin
      dat_a[2] = 9'(9'h030 + 9'(w));
      val_a[2] = 1'b1;
      k = 0;
      @(negedge clk);
      while (!rdy_w[2] && k < 200) begin
        @(negedge clk);
        k++;
      end
      chk("rdy_wait", 2, 16'(rdy_w[2]), 16'd1);
      @(posedge clk); #1;
      if (w == 4) begin
        @(negedge clk);
        chk("full_rdy", 2, 16'(rdy_w[2]), 16'd0);
        chk("full_level", 2, 16'(lvl[2]), 16'd4);
      end
    end
    val_a[2] = 1'b0;
    wait_idle(2, 1000);

    // Reset during data bit 3 with two words queued.
    @(posedge clk); #1;
    div_a[2] = 16'd4;
    for (int w = 0; w < 3; w++) begin
      dat_a[2] = 9'(9'h011 * 9'(w + 1));
      val_a[2] = 1'b1;
      @(posedge clk); #1;
    end
    val_a[2] = 1'b0;
    @(negedge clk);
    chk("queued", 2, 16'(lvl[2]), 16'd2);
    repeat (16) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_tx", 2, 16'(tx_w[2]), 16'd1);
    chk("abort_level", 2, 16'(lvl[2]), 16'd0);
    chk("abort_busy", 2, 16'(busy_w[2]), 16'd0);
    cnt0 = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx_w[2] == 1'b0) cnt0++;
    end
    chk("no_restart", 2, 16'(cnt0), 16'd0);

    rand_phase(1500, 5);
    rand_phase(1500, 60);
    for (int i = 0; i < NI; i++) wait_idle(i, 4000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
